// File: rtl/struct_field_unpacker.sv
// Bit-serial (MSB first) receiver that rebuilds packed {x[], y[], z} records and splits them into fields.
// Optional macro STRUCT_UNPACK_PARITY_EN appends a trailing even-parity bit to every serial frame.
module struct_field_unpacker #(
  parameter int X_W = 3,
  parameter int X_N = 2,
  parameter int Y_W = 2,
  parameter int Y_N = 3,
  localparam int REC_W = X_N*X_W + Y_N*Y_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  input  logic               in_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REC_W-1:0]   out_word,
  output logic [X_N*X_W-1:0] out_x,
  output logic [Y_N*Y_W-1:0] out_y,
  output logic               out_z,
  output logic               sync_err,
  output logic               out_perr
);

`ifdef STRUCT_UNPACK_PARITY_EN
  localparam int FRAME_W = REC_W + 1;
`else
  localparam int FRAME_W = REC_W;
`endif
  localparam int SHIFT_W = FRAME_W - 1;
  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  // FSM state and bit count travel together so both are visible as one struct.
  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] count;
  } ctl_t;

  // Valid/ready: a bit moves when in_valid && in_ready, a record moves when
  // out_valid && out_ready; data is held stable while valid is high and ready low.
  ctl_t               ctl;
  logic [SHIFT_W-1:0] shift;
  logic               in_fire;
  logic               out_fire;

  // Only the frame's final bit can stall, and only if the output slot cannot drain.
  assign in_ready = !(ctl.count == LAST && out_valid && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef STRUCT_UNPACK_PARITY_EN
  logic perr_q;
  assign out_perr = perr_q;
`else
  assign out_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl       <= '{state: IDLE, count: '0};
      shift     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      sync_err  <= 1'b0;
`ifdef STRUCT_UNPACK_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      sync_err <= 1'b0;
      if (out_fire) out_valid <= 1'b0;
      if (in_fire) begin
        if (in_start) begin
          // A start inside a partial frame abandons it and begins a fresh one.
          sync_err <= (ctl.state == COLLECT);
          shift    <= SHIFT_W'(in_bit);
          ctl      <= '{state: COLLECT, count: CNT_W'(1)};
        end else if (ctl.state == IDLE) begin
          sync_err <= 1'b1;
        end else if (ctl.count == LAST) begin
          ctl       <= '{state: IDLE, count: '0};
          out_valid <= 1'b1;
`ifdef STRUCT_UNPACK_PARITY_EN
          out_word  <= shift;
          perr_q    <= ^{shift, in_bit};
`else
          out_word  <= {shift, in_bit};
`endif
        end else begin
          shift     <= {shift[SHIFT_W-2:0], in_bit};
          ctl.count <= ctl.count + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < X_N; i++) begin : g_x
    assign out_x[i*X_W +: X_W] = out_word[REC_W-1-(X_N-1-i)*X_W -: X_W];
  end

  // y_0 arrives first, so it sits at the top of the y slice; flip it to the LSBs.
  for (genvar j = 0; j < Y_N; j++) begin : g_y
    assign out_y[j*Y_W +: Y_W] = out_word[Y_N*Y_W - j*Y_W -: Y_W];
  end

  assign out_z = out_word[0];

endmodule
